// File: rtl/dataflow_gates.sv
// -----------------------------------------------------------------------------
// dataflow_gates
//   Two-operand bitwise logic unit. It computes AND, OR, NAND, NOR, XOR, XNOR
//   and NOT(a) in parallel, plus one result chosen by an opcode. Every result
//   is registered with a single cycle of latency and is qualified by out_valid.
//
// Parameters
//   WIDTH      operand/result width in bits (>= 1); all operations are bitwise
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous assert, active-low reset
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   in_valid   in   1      a/b/op qualify this cycle
//   op         in   3      out_sel select:
//                          0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR,
//                          6 NOT a, 7 pass-through a
//   out_and    out  WIDTH  a & b
//   out_or     out  WIDTH  a | b
//   out_nand   out  WIDTH  ~(a & b)
//   out_nor    out  WIDTH  ~(a | b)
//   out_xor    out  WIDTH  a ^ b
//   out_xnor   out  WIDTH  ~(a ^ b)
//   out_not    out  WIDTH  ~a
//   out_sel    out  WIDTH  result picked by op
//   out_valid  out  1      results correspond to an accepted input
// -----------------------------------------------------------------------------
module dataflow_gates #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] out_and,
  output logic [WIDTH-1:0] out_or,
  output logic [WIDTH-1:0] out_nand,
  output logic [WIDTH-1:0] out_nor,
  output logic [WIDTH-1:0] out_xor,
  output logic [WIDTH-1:0] out_xnor,
  output logic [WIDTH-1:0] out_not,
  output logic [WIDTH-1:0] out_sel,
  output logic             out_valid
);

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  // One bundle for every registered result so capture, hold and reset are
  // handled as a single unit.
  typedef struct packed {
    logic [WIDTH-1:0] and_r;
    logic [WIDTH-1:0] or_r;
    logic [WIDTH-1:0] nand_r;
    logic [WIDTH-1:0] nor_r;
    logic [WIDTH-1:0] xor_r;
    logic [WIDTH-1:0] xnor_r;
    logic [WIDTH-1:0] not_r;
    logic [WIDTH-1:0] sel_r;
  } result_t;

  result_t res_d, res_q;
  logic    valid_q;

  // The complements are registered in their own right rather than derived
  // from the AND/OR/XOR flops, so that reset drives every output to zero.
  always_comb begin
    // NOTE: every field gets a value before the case below; a path that
    // leaves a combinational output unassigned would infer a latch.
    res_d        = '0;
    res_d.and_r  = a & b;
    res_d.or_r   = a | b;
    res_d.nand_r = ~(a & b);
    res_d.nor_r  = ~(a | b);
    res_d.xor_r  = a ^ b;
    res_d.xnor_r = ~(a ^ b);
    res_d.not_r  = ~a;

    unique case (op_e'(op))
      OP_AND:  res_d.sel_r = res_d.and_r;
      OP_OR:   res_d.sel_r = res_d.or_r;
      OP_NAND: res_d.sel_r = res_d.nand_r;
      OP_NOR:  res_d.sel_r = res_d.nor_r;
      OP_XOR:  res_d.sel_r = res_d.xor_r;
      OP_XNOR: res_d.sel_r = res_d.xnor_r;
      OP_NOT:  res_d.sel_r = res_d.not_r;
      OP_PASS: res_d.sel_r = a;
      default: res_d.sel_r = '0;
    endcase
  end

  // The result registers load only on accepted inputs, so operands (even X)
  // presented with in_valid low never reach the outputs. out_valid tracks
  // in_valid every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (!rst_n) begin
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        res_q <= res_d;
      end
    end
  end

  assign out_and   = res_q.and_r;
  assign out_or    = res_q.or_r;
  assign out_nand  = res_q.nand_r;
  assign out_nor   = res_q.nor_r;
  assign out_xor   = res_q.xor_r;
  assign out_xnor  = res_q.xnor_r;
  assign out_not   = res_q.not_r;
  assign out_sel   = res_q.sel_r;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_dataflow_gates.sv
// -----------------------------------------------------------------------------
// tb_dataflow_gates
//   Directed bench for dataflow_gates. It uses one WIDTH=1 instance for the
//   truth table, hold and reset cases, and one WIDTH=8 instance for the opcode
//   sweep. The two instances share the clock and the reset.
// -----------------------------------------------------------------------------
module tb_dataflow_gates;

  logic clk;
  logic rst_n;

  // WIDTH = 1 instance
  logic       a1, b1, iv1;
  logic [2:0] op1;
  logic       and1, or1, nand1, nor1, xor1, xnor1, not1, sel1, ov1;

  // WIDTH = 8 instance
  logic [7:0] a8, b8;
  logic       iv8;
  logic [2:0] op8;
  logic [7:0] and8, or8, nand8, nor8, xor8, xnor8, not8, sel8;
  logic       ov8;

  int n_pass  = 0;
  int n_total = 0;

  dataflow_gates #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(iv1), .op(op1),
    .out_and(and1), .out_or(or1), .out_nand(nand1), .out_nor(nor1),
    .out_xor(xor1), .out_xnor(xnor1), .out_not(not1), .out_sel(sel1),
    .out_valid(ov1)
  );

  dataflow_gates #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .in_valid(iv8), .op(op8),
    .out_and(and8), .out_or(or8), .out_nand(nand8), .out_nor(nor8),
    .out_xor(xor8), .out_xnor(xnor8), .out_not(not8), .out_sel(sel8),
    .out_valid(ov8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // The seven parallel results of the WIDTH=1 instance, packed in the order
  // {and, or, nand, nor, xor, xnor, not}.
  task automatic check_w1(input string tag, input logic [6:0] exp);
    check({tag, " and"},  32'(and1),  32'(exp[6]));
    check({tag, " or"},   32'(or1),   32'(exp[5]));
    check({tag, " nand"}, 32'(nand1), 32'(exp[4]));
    check({tag, " nor"},  32'(nor1),  32'(exp[3]));
    check({tag, " xor"},  32'(xor1),  32'(exp[2]));
    check({tag, " xnor"}, 32'(xnor1), 32'(exp[1]));
    check({tag, " not"},  32'(not1),  32'(exp[0]));
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed truth table rows for (a,b) = 00, 01, 10, 11.
  logic [6:0] tt_exp [4] = '{7'b0011011, 7'b0110101, 7'b0110100, 7'b1100010};
  // Hand-computed out_sel for a=F0, b=CC across op = 0..7.
  logic [7:0] sweep_exp [8] = '{8'hC0, 8'hFC, 8'h3F, 8'h03,
                                8'h3C, 8'hC3, 8'h0F, 8'hF0};

  initial begin
    rst_n = 1'b0;
    a1 = 1'b0; b1 = 1'b0; iv1 = 1'b0; op1 = 3'd0;
    a8 = 8'h00; b8 = 8'h00; iv8 = 1'b0; op8 = 3'd0;

    // 1. Reset is already in effect before the first clock edge.
    #2;
    check_w1("reset w1", 7'b0000000);
    check("reset w1 sel",   32'(sel1), 32'h0);
    check("reset w1 valid", 32'(ov1),  32'h0);
    check("reset w8 and",   32'(and8), 32'h0);
    check("reset w8 nand",  32'(nand8), 32'h0);
    check("reset w8 sel",   32'(sel8), 32'h0);
    check("reset w8 valid", 32'(ov8),  32'h0);

    @(negedge clk);
    rst_n = 1'b1;

    // 2. WIDTH=1 truth table with op=7, so out_sel passes a through.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a1 = i[1]; b1 = i[0]; iv1 = 1'b1; op1 = 3'd7;
      after_edge();
      check_w1($sformatf("tt a%0d b%0d", i / 2, i % 2), tt_exp[i]);
      check($sformatf("tt sel %0d", i), 32'(sel1), 32'(i / 2));
      check($sformatf("tt valid %0d", i), 32'(ov1), 32'h1);
    end

    // 3. WIDTH=8 opcode sweep, then one extra full-result vector.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      a8 = 8'hF0; b8 = 8'hCC; op8 = 3'(k); iv8 = 1'b1;
      after_edge();
      check($sformatf("sweep sel op%0d", k), 32'(sel8), 32'(sweep_exp[k]));
      check($sformatf("sweep valid op%0d", k), 32'(ov8), 32'h1);
    end
    @(negedge clk);
    a8 = 8'hA5; b8 = 8'h0F; op8 = 3'd5; iv8 = 1'b1;
    after_edge();
    check("w8 and",  32'(and8),  32'h05);
    check("w8 or",   32'(or8),   32'hAF);
    check("w8 nand", 32'(nand8), 32'hFA);
    check("w8 nor",  32'(nor8),  32'h50);
    check("w8 xor",  32'(xor8),  32'hAA);
    check("w8 xnor", 32'(xnor8), 32'h55);
    check("w8 not",  32'(not8),  32'h5A);
    check("w8 sel",  32'(sel8),  32'h55);
    @(negedge clk);
    iv8 = 1'b0;

    // 4. Hold: accept a=1,b=1 (op OR), then five idle cycles with moving
    // operands, including X.
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; op1 = 3'd1; iv1 = 1'b1;
    after_edge();
    check_w1("hold load", 7'b1100010);
    check("hold load valid", 32'(ov1), 32'h1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      iv1 = 1'b0;
      a1 = (c == 2) ? 1'bx : c[0];
      b1 = (c == 3) ? 1'bx : ~c[0];
      op1 = 3'(c);
      after_edge();
      check_w1($sformatf("hold c%0d", c), 7'b1100010);
      check($sformatf("hold sel c%0d", c), 32'(sel1), 32'h1);
      check($sformatf("hold valid c%0d", c), 32'(ov1), 32'h0);
    end

    // 5. Mid-stream reset between edges, with a valid input pending.
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b1; op1 = 3'd4; iv1 = 1'b1;
    after_edge();
    check("pre-rst valid", 32'(ov1), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_w1("midrst w1", 7'b0000000);
    check("midrst sel",   32'(sel1), 32'h0);
    check("midrst valid", 32'(ov1),  32'h0);
    check("midrst w8 and", 32'(and8), 32'h0);
    after_edge();
    check("midrst held xor", 32'(xor1), 32'h0);
    check("midrst held valid", 32'(ov1), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post-rel pre-edge valid", 32'(ov1), 32'h0);
    after_edge();
    check_w1("post-rst", 7'b0110101);
    check("post-rst sel",   32'(sel1), 32'h1);
    check("post-rst valid", 32'(ov1),  32'h1);
    check("post-rst w8 valid", 32'(ov8), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
